// File: rtl/input_cond_pkg.sv
`default_nettype none
// ============================================================================
// input_cond_pkg : shared defaults and per-channel output type
// Rev 1.0
// ============================================================================
package input_cond_pkg;

  localparam int DEF_DEBOUNCE_CYCLES     = 50000;
  localparam int DEF_SENSE_FILTER_CYCLES = 16;
  localparam int DEF_LONG_PRESS_CYCLES   = 1000000;

  typedef struct packed {
    logic level;
    logic pulse;
  } cond_out_t;

endpackage
`default_nettype wire

// File: rtl/input_conditioner_if.sv
`default_nettype none
// ============================================================================
// input_conditioner_if : raw inputs and conditioned outputs of the conditioner
// long_press_pulse present only with INPUT_COND_LONG_PRESS_EN. Rev 1.0
// ============================================================================
interface input_conditioner_if;
  logic mode_raw;
  logic sense_raw;
  logic mode_level;
  logic mode_pulse;
  logic sense_level;
  logic sense_pulse;
`ifdef INPUT_COND_LONG_PRESS_EN
  logic long_press_pulse;

  modport master (
    output mode_raw, sense_raw,
    input  mode_level, mode_pulse, sense_level, sense_pulse, long_press_pulse
  );
  modport slave (
    input  mode_raw, sense_raw,
    output mode_level, mode_pulse, sense_level, sense_pulse, long_press_pulse
  );
`else
  modport master (
    output mode_raw, sense_raw,
    input  mode_level, mode_pulse, sense_level, sense_pulse
  );
  modport slave (
    input  mode_raw, sense_raw,
    output mode_level, mode_pulse, sense_level, sense_pulse
  );
`endif
endinterface
`default_nettype wire

// File: rtl/input_conditioner_cond_channel.sv
`default_nettype none
// ============================================================================
// cond_channel : 2-flop synchronizer, N-cycle filter and rising-edge pulse
// Rev 1.0
// ============================================================================
module cond_channel #(
  parameter int N = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam int             CW     = $clog2(N + 1);
  localparam logic [CW-1:0]  C_LAST = CW'(N - 1);
  localparam logic [CW-1:0]  C_ONE  = CW'(1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          r_pulse;

  // Pulse is registered alongside the flip so it coincides with the first
  // cycle in which the new level is visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
      r_pulse  <= 1'b0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      r_pulse <= 1'b0;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == C_LAST) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
        r_pulse  <= r_sync2;
      end else begin
        r_cnt <= r_cnt + C_ONE;
      end
    end
  end

  assign level = r_stable;
  assign pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
// input_conditioner : mode/sense front-end; optional long press on mode
// Feature macro: INPUT_COND_LONG_PRESS_EN. Rev 1.0
// ============================================================================
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
  parameter int SENSE_FILTER_CYCLES = DEF_SENSE_FILTER_CYCLES,
  parameter int LONG_PRESS_CYCLES   = DEF_LONG_PRESS_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input_conditioner_if.slave  bus
);

  cond_out_t w_mode;
  cond_out_t w_sense;

  cond_channel #(.N(DEBOUNCE_CYCLES)) u_mode (
    .clk   (clk),
    .rst   (rst),
    .raw   (bus.mode_raw),
    .level (w_mode.level),
    .pulse (w_mode.pulse)
  );

  cond_channel #(.N(SENSE_FILTER_CYCLES)) u_sense (
    .clk   (clk),
    .rst   (rst),
    .raw   (bus.sense_raw),
    .level (w_sense.level),
    .pulse (w_sense.pulse)
  );

  assign bus.mode_level  = w_mode.level;
  assign bus.mode_pulse  = w_mode.pulse;
  assign bus.sense_level = w_sense.level;
  assign bus.sense_pulse = w_sense.pulse;

`ifdef INPUT_COND_LONG_PRESS_EN
  localparam int            HW         = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [HW-1:0] C_HOLD_MAX = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] C_HOLD_PRE = HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [HW-1:0] C_HOLD_ONE = HW'(1);

  logic [HW-1:0] r_hold;
  logic          r_long;

  // Saturating hold counter: fires once on reaching the limit, cleared on release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold <= '0;
      r_long <= 1'b0;
    end else begin
      r_long <= w_mode.level && (r_hold == C_HOLD_PRE);
      if (!w_mode.level) begin
        r_hold <= '0;
      end else if (r_hold != C_HOLD_MAX) begin
        r_hold <= r_hold + C_HOLD_ONE;
      end
    end
  end

  assign bus.long_press_pulse = r_long;
`endif

endmodule
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// ============================================================================
// tb_input_conditioner : directed vector bench for input_conditioner
// Covers INPUT_COND_LONG_PRESS_EN when defined. Rev 1.0
// ============================================================================
module tb_input_conditioner;

  typedef struct {
    logic       mode_raw;
    logic       sense_raw;
    logic [3:0] exp;   // {mode_level, mode_pulse, sense_level, sense_pulse}
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_bad = 0;
  vec_t tbl [20];

  always #5 clk = ~clk;

  input_conditioner_if ifa ();
  input_conditioner_if ifb ();

  input_conditioner #(
    .DEBOUNCE_CYCLES     (4),
    .SENSE_FILTER_CYCLES (2),
    .LONG_PRESS_CYCLES   (10)
  ) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  input_conditioner #(
    .DEBOUNCE_CYCLES     (3),
    .SENSE_FILTER_CYCLES (3),
    .LONG_PRESS_CYCLES   (10)
  ) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  function automatic logic [3:0] outs_a();
    return {ifa.mode_level, ifa.mode_pulse, ifa.sense_level, ifa.sense_pulse};
  endfunction

  function automatic logic [3:0] outs_b();
    return {ifb.mode_level, ifb.mode_pulse, ifb.sense_level, ifb.sense_pulse};
  endfunction

  task automatic check(input string nm, input int idx, input logic [3:0] act,
                       input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %b, want %b", nm, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Row i inputs are sampled at table edge i; outputs checked just after it.
    tbl[0]  = '{1'b1, 1'b1, 4'b0000};
    tbl[1]  = '{1'b0, 1'b0, 4'b0000};
    tbl[2]  = '{1'b1, 1'b1, 4'b0000};
    tbl[3]  = '{1'b0, 1'b0, 4'b0000};
    tbl[4]  = '{1'b1, 1'b0, 4'b0000};
    tbl[5]  = '{1'b1, 1'b0, 4'b0000};
    tbl[6]  = '{1'b1, 1'b1, 4'b0000};
    tbl[7]  = '{1'b1, 1'b1, 4'b0000};
    tbl[8]  = '{1'b1, 1'b1, 4'b0000};
    tbl[9]  = '{1'b1, 1'b0, 4'b1111};
    tbl[10] = '{1'b1, 1'b0, 4'b1010};
    tbl[11] = '{1'b1, 1'b0, 4'b1010};
    tbl[12] = '{1'b0, 1'b1, 4'b1000};
    tbl[13] = '{1'b0, 1'b1, 4'b1000};
    tbl[14] = '{1'b0, 1'b1, 4'b1000};
    tbl[15] = '{1'b0, 1'b0, 4'b1011};
    tbl[16] = '{1'b0, 1'b0, 4'b1010};
    tbl[17] = '{1'b0, 1'b0, 4'b0010};
    tbl[18] = '{1'b0, 1'b0, 4'b0000};
    tbl[19] = '{1'b0, 1'b0, 4'b0000};

    rst           = 1'b1;
    ifa.mode_raw  = 1'b1;
    ifa.sense_raw = 1'b0;
    ifb.mode_raw  = 1'b0;
    ifb.sense_raw = 1'b0;

    // Reset held with mode already high: everything stays low.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_a", i, outs_a(), 4'b0000);
      check("reset_b", i, outs_b(), 4'b0000);
    end
    rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check("release_requal", e, outs_a(), {e >= 6, e == 6, 1'b0, 1'b0});
    end
    ifa.mode_raw = 1'b0;
    repeat (10) tick();

    // Mode bounce then hold; sense 1-cycle glitches then 3-cycle pulses.
    for (int i = 0; i < 20; i++) begin
      ifa.mode_raw  = tbl[i].mode_raw;
      ifa.sense_raw = tbl[i].sense_raw;
      tick();
      check("table", i, outs_a(), tbl[i].exp);
    end
    repeat (10) tick();

    // Both channels N=3 rising together must pulse together.
    ifb.mode_raw  = 1'b1;
    ifb.sense_raw = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      check("simultaneous", e, outs_b(), {e >= 4, e == 4, e >= 4, e == 4});
    end
    ifb.mode_raw  = 1'b0;
    ifb.sense_raw = 1'b0;
    repeat (8) tick();

    // Reset mid-qualification (mode cnt=2 of 4, sense already high).
    ifa.mode_raw  = 1'b1;
    ifa.sense_raw = 1'b1;
    for (int e = 0; e < 4; e++) begin
      tick();
      check("pre_reset", e, outs_a(), {1'b0, 1'b0, e == 3, e == 3});
    end
    rst = 1'b1;
    #1;
    check("async_clear", 0, outs_a(), 4'b0000);
    tick();
    check("async_clear", 1, outs_a(), 4'b0000);
    rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check("mid_rst_requal", e, outs_a(), {e >= 6, e == 6, e >= 4, e == 4});
    end
    ifa.mode_raw  = 1'b0;
    ifa.sense_raw = 1'b0;
    repeat (12) tick();

`ifdef INPUT_COND_LONG_PRESS_EN
    // 20-cycle hold: level rises at edge 5, long press at edge 15.
    for (int e = 0; e < 30; e++) begin
      ifa.mode_raw = (e < 20);
      tick();
      check("long_press", e, {3'b000, ifa.long_press_pulse}, {3'b000, e == 15});
    end
    repeat (10) tick();
    // 8-cycle press is too short.
    for (int e = 0; e < 20; e++) begin
      ifa.mode_raw = (e < 8);
      tick();
      check("short_press", e, {3'b000, ifa.long_press_pulse}, 4'b0000);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
